// File: rtl/counter_mod.sv
// Up/down counter with a programmable terminal count (MAX_VAL), wrap or saturate at the limits,
// a one-cycle terminal-count pulse and a sticky boundary flag.
module counter_mod #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = '1,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] val,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] val_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;
  logic             at_top;
  logic             at_bot;

  assign at_top = (val == MAX_VAL);
  assign at_bot = (val == '0);

  // clr > load > count > hold; tc only ever comes from a counted boundary crossing
  always_comb begin
    val_nxt = val;
    tc_nxt  = 1'b0;
    ovf_nxt = ovf;
    if (clr) begin
      val_nxt = '0;
      ovf_nxt = 1'b0;
    end else if (load) begin
      val_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up) begin
        if (at_top) begin
          val_nxt = SATURATE ? MAX_VAL : '0;
          tc_nxt  = 1'b1;
          ovf_nxt = 1'b1;
        end else begin
          val_nxt = val + 1'b1;
        end
      end else begin
        if (at_bot) begin
          val_nxt = SATURATE ? '0 : MAX_VAL;
          tc_nxt  = 1'b1;
          ovf_nxt = 1'b1;
        end else begin
          val_nxt = val - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      val <= val_nxt;
      tc  <= tc_nxt;
      ovf <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_counter_mod.sv
// Directed bench for counter_mod: wrap and saturate instances (WIDTH=4, MAX_VAL=9) plus a
// default-parameter instance, checked through an expectation queue.
module tb_counter_mod;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up, load, clr;
  logic [3:0] load_val;
  logic       en8, up8, load8, clr8;
  logic [7:0] load_val8;

  logic [3:0] val_w, val_s;
  logic [7:0] val_d;
  logic       tc_w, tc_s, tc_d, ovf_w, ovf_s, ovf_d;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      tag;
    int         dut;
    logic [7:0] v;
    logic       tc;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  counter_mod #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr(clr), .val(val_w), .tc(tc_w), .ovf(ovf_w));

  counter_mod #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr(clr), .val(val_s), .tc(tc_s), .ovf(ovf_s));

  counter_mod u_def (
    .clk(clk), .rst(rst), .en(en8), .up(up8), .load(load8), .load_val(load_val8),
    .clr(clr8), .val(val_d), .tc(tc_d), .ovf(ovf_d));

  task automatic push(input string tag, input int dut, input int v, input logic t, input logic o);
    exp_t e;
    e.tag = tag;
    e.dut = dut;
    e.v   = 8'(v);
    e.tc  = t;
    e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t       e;
    logic [7:0] ov;
    logic       ot, oo;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.dut)
        0:       begin ov = {4'b0, val_w}; ot = tc_w; oo = ovf_w; end
        1:       begin ov = {4'b0, val_s}; ot = tc_s; oo = ovf_s; end
        default: begin ov = val_d;         ot = tc_d; oo = ovf_d; end
      endcase
      n_cmp++;
      assert (ov === e.v) else begin
        n_bad++;
        $error("FAIL %s dut%0d val: observed %0d expected %0d", e.tag, e.dut, ov, e.v);
      end
      n_cmp++;
      assert (ot === e.tc) else begin
        n_bad++;
        $error("FAIL %s dut%0d tc: observed %b expected %b", e.tag, e.dut, ot, e.tc);
      end
      n_cmp++;
      assert (oo === e.ovf) else begin
        n_bad++;
        $error("FAIL %s dut%0d ovf: observed %b expected %b", e.tag, e.dut, oo, e.ovf);
      end
    end
  endtask

  // one clock edge, checking both 4-bit instances afterwards
  task automatic step(input string tag, input int wv, input logic wt, input logic wo,
                      input int sv, input logic st, input logic so);
    push(tag, 0, wv, wt, wo);
    push(tag, 1, sv, st, so);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic step_d(input string tag, input int dv, input logic dt, input logic dov);
    push(tag, 2, dv, dt, dov);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    rst = 1'b0;
    #1;
    push(tag, 0, 0, 1'b0, 1'b0);
    push(tag, 1, 0, 1'b0, 1'b0);
    push(tag, 2, 0, 1'b0, 1'b0);
    check_all();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    en = 1'b0; up = 1'b0; load = 1'b0; clr = 1'b0; load_val = 4'd0;
    en8 = 1'b0; up8 = 1'b0; load8 = 1'b0; clr8 = 1'b0; load_val8 = 8'd0;
    #2;
    push("reset", 0, 0, 1'b0, 1'b0);
    push("reset", 1, 0, 1'b0, 1'b0);
    push("reset", 2, 0, 1'b0, 1'b0);
    check_all();

    // inputs are ignored while reset is held
    en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd7;
    step("in_reset", 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    load = 1'b0;
    rst = 1'b1;

    for (int i = 1; i <= 12; i++)
      step("count_up", i % 10, i == 10, i >= 10,
           (i < 9) ? i : 9, i >= 10, i >= 10);

    // load clamps to MAX_VAL, no tc, ovf untouched
    en = 1'b0; load = 1'b1; load_val = 4'd15;
    step("load_clamp", 9, 1'b0, 1'b1, 9, 1'b0, 1'b1);
    load = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 1; i <= 11; i++)
      step("count_dn", (i <= 9) ? 9 - i : ((i == 10) ? 9 : 8), i == 10, 1'b1,
           (i <= 9) ? 9 - i : 0, i >= 10, 1'b1);

    en = 1'b0; clr = 1'b1;
    step("clr", 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    clr = 1'b0; load = 1'b1; load_val = 4'd9;
    step("load9", 9, 1'b0, 1'b0, 9, 1'b0, 1'b0);
    en = 1'b1; up = 1'b1; clr = 1'b1;
    step("clr_wins", 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    clr = 1'b0;
    step("load9b", 9, 1'b0, 1'b0, 9, 1'b0, 1'b0);

    // saturating instance sits at the top and pulses tc every cycle
    load = 1'b0;
    step("top1", 0, 1'b1, 1'b1, 9, 1'b1, 1'b1);
    step("top2", 1, 1'b0, 1'b1, 9, 1'b1, 1'b1);
    step("top3", 2, 1'b0, 1'b1, 9, 1'b1, 1'b1);
    en = 1'b0;
    step("hold", 2, 1'b0, 1'b1, 9, 1'b0, 1'b1);

    en = 1'b1; up = 1'b0;
    step("dir_dn", 1, 1'b0, 1'b1, 8, 1'b0, 1'b1);
    up = 1'b1;
    step("dir_up", 2, 1'b0, 1'b1, 9, 1'b0, 1'b1);
    en = 1'b0; load = 1'b1; load_val = 4'd5;
    step("load5", 5, 1'b0, 1'b1, 5, 1'b0, 1'b1);
    load = 1'b0;

    clr = 1'b1;
    step("clr2", 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    clr = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 5; i++)
      step("to5", i, 1'b0, 1'b0, i, 1'b0, 1'b0);
    async_reset_check("async_rst_mid_count");
    step("held_rst", 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    rst = 1'b1;
    step("resume", 1, 1'b0, 1'b0, 1, 1'b0, 1'b0);

    en = 1'b0; load = 1'b1; load_val = 4'd9;
    step("load9c", 9, 1'b0, 1'b0, 9, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1; up = 1'b1;
    step("tc_before_rst", 0, 1'b1, 1'b1, 9, 1'b1, 1'b1);
    async_reset_check("async_rst_mid_tc");
    #1;
    rst = 1'b1;
    en = 1'b0;
    step("no_residual_tc", 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    load8 = 1'b1; load_val8 = 8'd255;
    step_d("def_load255", 255, 1'b0, 1'b0);
    load8 = 1'b0; en8 = 1'b1; up8 = 1'b1;
    step_d("def_wrap", 0, 1'b1, 1'b1);
    step_d("def_after", 1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
